// File: rtl/keep_one_in_n_pkg.sv
// Shared constants for the QPSK 4:1 packer/unpacker pair: lane order and expand modes.
package keep_one_in_n_pkg;
    localparam int LANES = 4;
    // Byte position of each lane inside the packed word, in emit order.
    localparam int LANE_LSB [0:LANES-1] = '{16, 24, 0, 8};

    localparam logic EXPAND_BYTE   = 1'b0;
    localparam logic EXPAND_NIBBLE = 1'b1;

    typedef enum logic {EMPTY = 1'b0, DRAIN = 1'b1} unzip_state_t;
endpackage

// File: rtl/unzip_lane_expand.sv
// Expands one packed symbol byte into a 32-bit IQ sample (I [31:16], Q [15:0]).
module unzip_lane_expand
    import keep_one_in_n_pkg::*;
(
    input  logic [7:0]  sym,
    input  logic        mode,
    output logic [31:0] sample
);
    always_comb begin
        sample = '0;
        case (mode)
            EXPAND_BYTE:   sample[31:24] = sym;
            EXPAND_NIBBLE: begin
                sample[31:28] = sym[7:4];
                sample[15:12] = sym[3:0];
            end
        endcase
    end
endmodule

// File: rtl/keep_one_in_n_unzip.sv
// 1:4 unpacker: one packed 32-bit word in, four expanded IQ samples out, AXI-Stream both sides.
module keep_one_in_n_unzip
    import keep_one_in_n_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int EXPAND_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready
);
    localparam logic MODE = (EXPAND_MODE != 0) ? EXPAND_NIBBLE : EXPAND_BYTE;

    unzip_state_t     state, state_n;
    logic [1:0]       lane, lane_n;
    logic [WIDTH-1:0] hold_data;
    logic             hold_last;
    logic             load;
    logic             full;
    logic             last_lane;

    logic [LANES-1:0][WIDTH-1:0] lane_sample;

    assign full      = (state == DRAIN);
    assign last_lane = (lane == 2'd3);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        unzip_lane_expand u_expand (
            .sym    (hold_data[LANE_LSB[g] +: 8]),
            .mode   (MODE),
            .sample (lane_sample[g])
        );
    end

    // Outputs depend on registers only; i_tready also looks at o_tready so the
    // next word loads on the same edge the final lane leaves.
    assign o_tvalid = full;
    assign o_tdata  = full ? lane_sample[lane] : '0;
    assign o_tlast  = full & hold_last & last_lane;

    always_comb begin
        state_n  = state;
        lane_n   = lane;
        load     = 1'b0;
        i_tready = ~full | (last_lane & o_tready);
        case (state)
            EMPTY: begin
                if (i_tvalid) begin
                    load    = 1'b1;
                    lane_n  = 2'd0;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (o_tready) begin
                    if (!last_lane) begin
                        lane_n = lane + 2'd1;
                    end else if (i_tvalid) begin
                        load   = 1'b1;
                        lane_n = 2'd0;
                    end else begin
                        state_n = EMPTY;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= EMPTY;
            lane      <= 2'd0;
            hold_data <= '0;
            hold_last <= 1'b0;
        end else begin
            state <= state_n;
            lane  <= lane_n;
            if (load) begin
                hold_data <= i_tdata;
                hold_last <= i_tlast;
            end
        end
    end
endmodule
